dmem_responder: RTL and testbench

Handshaked data-memory responder: the slave end of the pipeline's load/store port. Accepts one request at a time (address, write data, byte/half/word size, load signedness). Holds it for a programmable latency, then commits the store or performs the load with byte-lane extraction and sign/zero extension. Returns a completion response that the initiator may backpressure. It replaces the zero-latency combinational data memory so the pipeline can be exercised against realistic memory timing.

---
 rtl/dmem_responder.sv | 260 ++++++++++++++++++++++++++
 tb/tb_dmem_responder.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_responder
//  Purpose  : Handshaked data-memory responder. Accepts one load/store request
//             at a time, holds it for LATENCY wait cycles, performs the access
//             in a single COMMIT cycle (byte-lane writes, lane extraction and
//             sign/zero extension for loads), then presents a response that
//             the initiator may backpressure.
//  Ports    : clk, reset          - clock, synchronous active-high reset
//             req_valid/req_ready - request handshake
//             req_we, req_addr, req_wdata, req_size, req_lunsigned
//                                 - request fields (size 00 W, 01 H, 10 B)
//             rsp_valid/rsp_ready - response handshake
//             rsp_rdata, rsp_err  - load result (0 for stores/errors), error
//  Notes    : The lane logic assumes a 32-bit word (four byte lanes).
//  Revision : 1.0 - initial release
// ============================================================================
module dmem_responder #(
    parameter int XLEN        = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    input  logic [1:0]      req_size,
    input  logic            req_lunsigned,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_rdata,
    output logic            rsp_err
);

    localparam int          AW     = $clog2(DEPTH_WORDS);
    localparam int          NLANES = XLEN / 8;
    localparam int          CNT_W  = 4;
    localparam logic [CNT_W-1:0] LAT_C = CNT_W'(LATENCY);

    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_WAIT   = 2'd1;
    localparam logic [1:0] S_COMMIT = 2'd2;
    localparam logic [1:0] S_RESP   = 2'd3;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             we_q;
    logic [XLEN-1:0]  addr_q;
    logic [XLEN-1:0]  wdata_q;
    logic [1:0]       size_q;
    logic             lunsigned_q;

    logic [XLEN-1:0]  rsp_rdata_q;
    logic             rsp_err_q;

    logic [XLEN-1:0]  mem_q [DEPTH_WORDS];

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic              accept;
    logic              commit;
    logic              mem_wr_en;
    logic              err;
    logic [AW-1:0]     idx;
    logic [NLANES-1:0] be;
    logic [XLEN-1:0]   wlane;
    logic [XLEN-1:0]   rd_word;
    logic [7:0]        rd_byte;
    logic [15:0]       rd_half;
    logic [XLEN-1:0]   load_val;
    logic              unused_addr_hi;

    // Upper address bits are deliberately ignored so addresses alias.
    assign unused_addr_hi = ^addr_q[XLEN-1:AW+2];

    assign idx = addr_q[AW+1:2];

    always_comb begin
        err = 1'b0;
        unique case (size_q)
            SZ_WORD: err = (addr_q[1:0] != 2'b00);
            SZ_HALF: err = addr_q[0];
            SZ_BYTE: err = 1'b0;
            default: err = 1'b1;
        endcase
    end

    // Byte enables and lane-replicated store data: replicating the narrow
    // value across all lanes lets the enables alone pick the target lane.
    always_comb begin
        be    = '0;
        wlane = wdata_q;
        unique case (size_q)
            SZ_WORD: begin
                be    = '1;
                wlane = wdata_q;
            end
            SZ_HALF: begin
                be    = addr_q[1] ? 4'b1100 : 4'b0011;
                wlane = {(XLEN/16){wdata_q[15:0]}};
            end
            SZ_BYTE: begin
                be    = 4'b0001 << addr_q[1:0];
                wlane = {(XLEN/8){wdata_q[7:0]}};
            end
            default: begin
                be    = '0;
                wlane = wdata_q;
            end
        endcase
    end

    assign rd_word = mem_q[idx];
    assign rd_byte = rd_word[{addr_q[1:0], 3'b000} +: 8];
    assign rd_half = rd_word[{addr_q[1], 4'b0000} +: 16];

    always_comb begin
        load_val = rd_word;
        unique case (size_q)
            SZ_HALF: load_val = lunsigned_q ? {{(XLEN-16){1'b0}}, rd_half}
                                            : {{(XLEN-16){rd_half[15]}}, rd_half};
            SZ_BYTE: load_val = lunsigned_q ? {{(XLEN-8){1'b0}}, rd_byte}
                                            : {{(XLEN-8){rd_byte[7]}}, rd_byte};
            default: load_val = rd_word;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    cnt_d   = LAT_C;
                    state_d = (LATENCY == 0) ? S_COMMIT : S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 1'b1;
                // <= guards against a stray zero count trapping the FSM.
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = S_COMMIT;
                end
            end
            S_COMMIT: begin
                state_d = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: output logic
    // ------------------------------------------------------------------
    always_comb begin
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        accept    = 1'b0;
        commit    = 1'b0;
        mem_wr_en = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                // Held low while reset is asserted even if already idle.
                req_ready = ~reset;
                accept    = req_valid & ~reset;
            end
            S_COMMIT: begin
                commit = ~reset;
                // A reset coinciding with the commit edge aborts the store.
                mem_wr_en = we_q & ~err & ~reset;
            end
            S_RESP: begin
                rsp_valid = 1'b1;
            end
            default: begin
                req_ready = 1'b0;
            end
        endcase
    end

    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

    // ------------------------------------------------------------------
    // Request latch and response registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            size_q      <= SZ_WORD;
            lunsigned_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            if (accept) begin
                we_q        <= req_we;
                addr_q      <= req_addr;
                wdata_q     <= req_wdata;
                size_q      <= req_size;
                lunsigned_q <= req_lunsigned;
            end
            if (commit) begin
                rsp_err_q   <= err;
                rsp_rdata_q <= (err || we_q) ? '0 : load_val;
            end
        end
    end

    // ------------------------------------------------------------------
    // Storage: not reset, written lane-by-lane at the commit edge
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (mem_wr_en) begin
            for (int i = 0; i < NLANES; i++) begin
                if (be[i]) begin
                    mem_q[idx][8*i +: 8] <= wlane[8*i +: 8];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_dmem_responder
//  Purpose  : Self-checking bench for dmem_responder. Two instances (LATENCY
//             2 and 0) share the request bus; a byte-array reference model
//             predicts load data, errors and response latency.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

    localparam int XLEN  = 32;
    localparam int DEPTH = 1024;
    localparam int LAT0  = 2;
    localparam int LAT1  = 0;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [1:0]  req_size = '0;
    logic        req_lunsigned = 1'b0;
    logic        rsp_ready = 1'b0;
    int          sel = 0;

    logic        rr0, rv0, re0, rr1, rv1, re1;
    logic [31:0] rd0, rd1;
    logic        o_rr, o_rv, o_re;
    logic [31:0] o_rd;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] mdl [2][4096];

    always #5 clk = ~clk;

    dmem_responder #(.XLEN(XLEN), .DEPTH_WORDS(DEPTH), .LATENCY(LAT0)) u_dut0 (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid && (sel == 0)),
        .req_ready    (rr0),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_size     (req_size),
        .req_lunsigned(req_lunsigned),
        .rsp_valid    (rv0),
        .rsp_ready    (rsp_ready && (sel == 0)),
        .rsp_rdata    (rd0),
        .rsp_err      (re0)
    );

    dmem_responder #(.XLEN(XLEN), .DEPTH_WORDS(DEPTH), .LATENCY(LAT1)) u_dut1 (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid && (sel == 1)),
        .req_ready    (rr1),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_size     (req_size),
        .req_lunsigned(req_lunsigned),
        .rsp_valid    (rv1),
        .rsp_ready    (rsp_ready && (sel == 1)),
        .rsp_rdata    (rd1),
        .rsp_err      (re1)
    );

    assign o_rr = (sel == 1) ? rr1 : rr0;
    assign o_rv = (sel == 1) ? rv1 : rv0;
    assign o_re = (sel == 1) ? re1 : re0;
    assign o_rd = (sel == 1) ? rd1 : rd0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: little-endian byte memory, address wraps at 4*DEPTH.
    function automatic void model(input int d, input bit we, input logic [31:0] a,
                                  input logic [31:0] wd, input logic [1:0] sz,
                                  input bit lu, output logic [31:0] rd, output bit er);
        int     base;
        int     nb;
        longint v;
        base = int'(a % 32'(4 * DEPTH));
        nb   = (sz == 2'd0) ? 4 : (sz == 2'd1) ? 2 : 1;
        er   = (sz == 2'd3) || ((int'(a[1:0]) % nb) != 0);
        rd   = '0;
        if (!er) begin
            if (we) begin
                for (int i = 0; i < nb; i++) mdl[d][base+i] = 8'(wd >> (8*i));
            end else begin
                v = 0;
                for (int i = 0; i < nb; i++) v = v + (longint'(mdl[d][base+i]) << (8*i));
                if (nb < 4 && !lu && v >= (64'sd1 << (8*nb-1))) v = v - (64'sd1 << (8*nb));
                rd = 32'(v);
            end
        end
    endfunction

    task automatic txn(input int d, input bit we, input logic [31:0] a, input logic [31:0] wd,
                       input logic [1:0] sz, input bit lu, input int bp, output logic [31:0] got);
        logic [31:0] exp_rd;
        bit          exp_er;
        int          k;
        int          lat;
        logic [31:0] h_rd;
        logic        h_er;
        lat = (d == 0) ? LAT0 : LAT1;
        model(d, we, a, wd, sz, lu, exp_rd, exp_er);
        @(negedge clk);
        sel           = d;
        req_we        = we;
        req_addr      = a;
        req_wdata     = wd;
        req_size      = sz;
        req_lunsigned = lu;
        req_valid     = 1'b1;
        k = 0;
        #1;
        while (!o_rr && k < 50) begin
            @(negedge clk); #1; k++;
        end
        check("req_ready_idle", {31'b0, o_rr}, 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        check("req_ready_busy", {31'b0, o_rr}, 32'd0);
        k = 0;
        while (!o_rv && k < 50) begin
            @(negedge clk); #1; k++;
        end
        check("latency", 32'(k), 32'(lat + 1));
        check("rsp_err", {31'b0, o_re}, {31'b0, exp_er});
        check("rsp_rdata", o_rd, exp_rd);
        got  = o_rd;
        h_rd = o_rd;
        h_er = o_re;
        for (int i = 0; i < bp; i++) begin
            @(negedge clk); #1;
            check("bp_valid", {31'b0, o_rv}, 32'd1);
            check("bp_rdata", o_rd, h_rd);
            check("bp_err", {31'b0, o_re}, {31'b0, h_er});
            check("bp_req_ready", {31'b0, o_rr}, 32'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        #1;
        check("valid_after_hs", {31'b0, o_rv}, 32'd0);
        check("ready_after_hs", {31'b0, o_rr}, 32'd1);
    endtask

    // Store aborted by reset one cycle after acceptance; memory must not change.
    task automatic reset_abort(input int d, input logic [31:0] a, input logic [31:0] wd);
        @(negedge clk);
        sel       = d;
        req_we    = 1'b1;
        req_addr  = a;
        req_wdata = wd;
        req_size  = 2'd0;
        req_valid = 1'b1;
        #1;
        check("abort_ready", {31'b0, o_rr}, 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        reset     = 1'b1;
        @(negedge clk); #1;
        check("abort_valid", {31'b0, o_rv}, 32'd0);
        check("abort_err", {31'b0, o_re}, 32'd0);
        check("abort_rdata", o_rd, 32'd0);
        check("abort_ready_in_reset", {31'b0, o_rr}, 32'd0);
        reset = 1'b0;
        #1;
        check("abort_idle", {31'b0, o_rr}, 32'd1);
    endtask

    initial begin
        logic [31:0] got;
        logic [31:0] r;
        logic [7:0]  lo;
        int          d;
        logic [1:0]  sz;

        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        for (int i = 0; i < 2; i++) begin
            sel = i;
            #1;
            check("rst_req_ready", {31'b0, o_rr}, 32'd0);
            check("rst_rsp_valid", {31'b0, o_rv}, 32'd0);
            check("rst_rsp_rdata", o_rd, 32'd0);
            check("rst_rsp_err", {31'b0, o_re}, 32'd0);
        end
        reset = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            sel = i;
            #1;
            check("post_rst_ready", {31'b0, o_rr}, 32'd1);
        end

        // Fill the first 64 words of both memories.
        for (int dd = 0; dd < 2; dd++)
            for (int w = 0; w < 64; w++)
                txn(dd, 1'b1, 32'(w * 4), $urandom, 2'd0, 1'b0, 0, got);

        // Directed scenario on the LATENCY=2 instance.
        txn(0, 1, 32'h10, 32'hDEADBEEF, 2'd0, 0, 0, got);
        txn(0, 0, 32'h10, 32'h0, 2'd0, 0, 0, got);
        check("word_load", got, 32'hDEADBEEF);
        txn(0, 0, 32'h13, 32'h0, 2'd2, 0, 0, got);
        check("byte_signed", got, 32'hFFFFFFDE);
        txn(0, 0, 32'h13, 32'h0, 2'd2, 1, 0, got);
        check("byte_unsigned", got, 32'h000000DE);
        txn(0, 1, 32'h12, 32'h00001234, 2'd1, 0, 0, got);
        txn(0, 0, 32'h10, 32'h0, 2'd0, 0, 0, got);
        check("half_store", got, 32'h1234BEEF);
        txn(0, 1, 32'h11, 32'h0000005A, 2'd2, 0, 0, got);
        txn(0, 0, 32'h10, 32'h0, 2'd0, 0, 0, got);
        check("byte_store", got, 32'h12345AEF);
        txn(0, 0, 32'h10, 32'h0, 2'd1, 0, 0, got);
        check("half_signed", got, 32'h00005AEF);
        txn(0, 1, 32'h11, 32'hFFFFFFFF, 2'd1, 0, 0, got);
        txn(0, 0, 32'h12, 32'h0, 2'd0, 0, 0, got);
        txn(0, 1, 32'h10, 32'hFFFFFFFF, 2'd3, 0, 0, got);
        txn(0, 0, 32'h10, 32'h0, 2'd0, 0, 0, got);
        check("err_no_change", got, 32'h12345AEF);
        txn(0, 0, 32'h10 + 32'(4 * DEPTH), 32'h0, 2'd0, 0, 5, got);
        check("alias_bp", got, 32'h12345AEF);

        // Reset mid-operation on both latencies.
        reset_abort(0, 32'h20, 32'hCAFEF00D);
        txn(0, 0, 32'h20, 32'h0, 2'd0, 0, 0, got);
        reset_abort(1, 32'h20, 32'hCAFEF00D);
        txn(1, 0, 32'h20, 32'h0, 2'd0, 0, 0, got);

        // Randomized traffic across both instances.
        for (int n = 0; n < 300; n++) begin
            d  = int'($urandom_range(0, 1));
            r  = $urandom;
            lo = 8'($urandom_range(0, 255));
            sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            txn(d, 1'($urandom_range(0, 1)), {r[31:12], 4'b0000, lo}, $urandom, sz,
                1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), got);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
